// File: rtl/sdram_aref_sched_if.sv
// sdram_aref_sched_if: command-arbiter side of the SDRAM auto-refresh scheduler.
//   master (scheduler): drives aref_req, aref_urgent, aref_busy, aref_done,
//                       aref_cmd, aref_addr, aref_debt, aref_ovf;
//                       receives init_done, aref_gnt.
//   slave  (arbiter/controller): the mirror image.
// DEBT_W must equal $clog2(MAX_DEBT+1) of the attached scheduler.
interface sdram_aref_sched_if #(
    parameter int ADDR_W = 13,
    parameter int DEBT_W = 4
);
    logic              init_done;
    logic              aref_gnt;
    logic              aref_req;
    logic              aref_urgent;
    logic              aref_busy;
    logic              aref_done;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;
    logic [DEBT_W-1:0] aref_debt;
    logic              aref_ovf;

    modport master (
        input  init_done, aref_gnt,
        output aref_req, aref_urgent, aref_busy, aref_done,
        output aref_cmd, aref_addr, aref_debt, aref_ovf
    );

    modport slave (
        output init_done, aref_gnt,
        input  aref_req, aref_urgent, aref_busy, aref_done,
        input  aref_cmd, aref_addr, aref_debt, aref_ovf
    );
endinterface

// File: rtl/sdram_aref_sched.sv
// sdram_aref_sched: SDRAM auto-refresh scheduler. Accumulates elapsed refresh
// intervals as a debt, requests the command bus, and on grant issues one
// PRECHARGE ALL followed by an AREF burst that clears the debt latched at grant.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  sdram_aref_sched_if.master (init_done/aref_gnt in; request, status,
//        command, address, debt and overflow out)
//
// state      | meaning
// S_IDLE     | not owning the bus; aref_req = (debt != 0)
// S_PRE      | PRECHARGE ALL on the bus (1 cycle)
// S_WAIT_RP  | NOP, tRP spacing before the first AREF
// S_REF      | AUTO REFRESH on the bus (1 cycle)
// S_WAIT_RFC | NOP, tRFC spacing after each AREF
module sdram_aref_sched #(
    parameter int T_REFI_CYC = 390,
    parameter int T_RP_CYC   = 2,
    parameter int T_RFC_CYC  = 7,
    parameter int MAX_DEBT   = 8,
    parameter int URGENT_LVL = 6,
    parameter int ADDR_W     = 13
) (
    input logic               clk,
    input logic               rst,
    sdram_aref_sched_if.master bus
);
    localparam int DEBT_W  = $clog2(MAX_DEBT + 1);
    localparam int REFI_W  = $clog2(T_REFI_CYC);
    localparam int TMR_MAX = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI_CYC - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0] DEBT_URG  = DEBT_W'(URGENT_LVL);
    // Wait timers count down to zero; a load of N gives N+1 NOP cycles.
    localparam logic [TMR_W-1:0]  RP_LOAD   = TMR_W'((T_RP_CYC  >= 2) ? T_RP_CYC  - 2 : 0);
    localparam logic [TMR_W-1:0]  RFC_LOAD  = TMR_W'((T_RFC_CYC >= 2) ? T_RFC_CYC - 2 : 0);
    localparam logic [ADDR_W-1:0] ADDR_A10  = ADDR_W'(1) << 10;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
    } state_t;

    state_t            state;
    logic [REFI_W-1:0] refi_cnt;
    logic [DEBT_W-1:0] debt;
    logic [DEBT_W-1:0] debt_nxt;
    logic [DEBT_W-1:0] burst_left;
    logic [TMR_W-1:0]  tmr;
    logic              tick;
    logic              aref_fire;
    logic              ovf;
    logic              urgent;
    logic              req;
    logic              busy;
    logic              done;
    logic [3:0]        cmd;

    always_comb begin
        tick      = bus.init_done && (refi_cnt == REFI_LAST);
        aref_fire = bus.init_done && (state == S_REF);
        debt_nxt  = debt;
        // A tick and an AREF on the same edge cancel out.
        if (tick && !aref_fire && (debt != DEBT_MAX))
            debt_nxt = debt + DEBT_W'(1);
        else if (aref_fire && !tick)
            debt_nxt = debt - DEBT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refi_cnt <= '0;
            debt     <= '0;
            urgent   <= 1'b0;
            ovf      <= 1'b0;
        end else if (!bus.init_done) begin
            // ovf is deliberately kept: it records a lost refresh until rst.
            refi_cnt <= '0;
            debt     <= '0;
            urgent   <= 1'b0;
        end else begin
            refi_cnt <= tick ? '0 : refi_cnt + REFI_W'(1);
            debt     <= debt_nxt;
            urgent   <= (debt_nxt >= DEBT_URG);
            if (tick && (debt == DEBT_MAX))
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            burst_left <= '0;
            tmr        <= '0;
            cmd        <= CMD_NOP;
            busy       <= 1'b0;
            req        <= 1'b0;
            done       <= 1'b0;
        end else if (!bus.init_done) begin
            state      <= S_IDLE;
            burst_left <= '0;
            tmr        <= '0;
            cmd        <= CMD_NOP;
            busy       <= 1'b0;
            req        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req && bus.aref_gnt) begin
                        state      <= S_PRE;
                        burst_left <= debt;
                        cmd        <= CMD_PALL;
                        busy       <= 1'b1;
                        req        <= 1'b0;
                    end else begin
                        req <= (debt_nxt != '0);
                    end
                end
                S_PRE: begin
                    if (T_RP_CYC == 1) begin
                        state <= S_REF;
                        cmd   <= CMD_AREF;
                    end else begin
                        state <= S_WAIT_RP;
                        tmr   <= RP_LOAD;
                        cmd   <= CMD_NOP;
                    end
                end
                S_WAIT_RP: begin
                    if (tmr == '0) begin
                        state <= S_REF;
                        cmd   <= CMD_AREF;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_REF: begin
                    burst_left <= burst_left - DEBT_W'(1);
                    if (T_RFC_CYC >= 2) begin
                        state <= S_WAIT_RFC;
                        tmr   <= RFC_LOAD;
                        cmd   <= CMD_NOP;
                    end else if (burst_left != DEBT_W'(1)) begin
                        cmd <= CMD_AREF;
                    end else begin
                        state <= S_IDLE;
                        cmd   <= CMD_NOP;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        req   <= (debt_nxt != '0);
                    end
                end
                S_WAIT_RFC: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TMR_W'(1);
                    end else if (burst_left != '0) begin
                        state <= S_REF;
                        cmd   <= CMD_AREF;
                    end else begin
                        state <= S_IDLE;
                        cmd   <= CMD_NOP;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        req   <= (debt_nxt != '0);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cmd   <= CMD_NOP;
                    busy  <= 1'b0;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.aref_req    = req;
    assign bus.aref_urgent = urgent;
    assign bus.aref_busy   = busy;
    assign bus.aref_done   = done;
    assign bus.aref_cmd    = cmd;
    assign bus.aref_addr   = ADDR_A10;
    assign bus.aref_debt   = debt;
    assign bus.aref_ovf    = ovf;
endmodule

// File: tb/tb_sdram_aref_sched.sv
// Directed bench for sdram_aref_sched with T_REFI=20, T_RP=2, T_RFC=4,
// MAX_DEBT=4, URGENT_LVL=3. Outputs are sampled on the falling clock edge.
module tb_sdram_aref_sched;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PALL = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sdram_aref_sched_if #(.ADDR_W(13), .DEBT_W(3)) bus ();

    sdram_aref_sched #(
        .T_REFI_CYC(20), .T_RP_CYC(2), .T_RFC_CYC(4),
        .MAX_DEBT(4), .URGENT_LVL(3), .ADDR_W(13)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Grants once and records what the block puts on the bus until busy drops.
    task automatic do_burst(output int busy_len, output int n_aref, output int first_aref,
                            output int last_aref, output int n_pall, output int n_other,
                            output int done_at_fall, output int done_total);
        int i;
        busy_len = 0; n_aref = 0; first_aref = -1; last_aref = -1;
        n_pall = 0; n_other = 0; done_total = 0;
        bus.aref_gnt = 1'b1;
        @(negedge clk);
        bus.aref_gnt = 1'b0;
        i = 0;
        while (bus.aref_busy === 1'b1 && i < 100) begin
            if (bus.aref_cmd === PALL) begin
                n_pall++;
                if (i != 0) n_other++;
            end else if (bus.aref_cmd === AREF) begin
                n_aref++;
                if (first_aref < 0) first_aref = i;
                last_aref = i;
            end else if (bus.aref_cmd !== NOP) begin
                n_other++;
            end
            if (bus.aref_done === 1'b1) done_total++;
            @(negedge clk);
            i++;
        end
        busy_len     = i;
        done_at_fall = (bus.aref_done === 1'b1) ? 1 : 0;
        done_total  += done_at_fall;
        @(negedge clk);
        if (bus.aref_done === 1'b1) done_total++;
    endtask

    task automatic wait_debt(input int v, output int ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (int'(bus.aref_debt) == v) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int early;
        rst = 1'b1; bus.init_done = 1'b1; bus.aref_gnt = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.aref_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", bus.aref_req); end
        n_vec++; if (bus.aref_urgent !== 1'b0) begin n_err++; $display("FAIL rst_urgent got %b want 0", bus.aref_urgent); end
        n_vec++; if (bus.aref_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.aref_busy); end
        n_vec++; if (bus.aref_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", bus.aref_done); end
        n_vec++; if (bus.aref_cmd !== NOP) begin n_err++; $display("FAIL rst_cmd got %b want 0111", bus.aref_cmd); end
        n_vec++; if (bus.aref_debt !== 3'd0) begin n_err++; $display("FAIL rst_debt got %0d want 0", bus.aref_debt); end
        n_vec++; if (bus.aref_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", bus.aref_ovf); end
        n_vec++; if (bus.aref_addr !== 13'h0400) begin n_err++; $display("FAIL addr got %h want 0400", bus.aref_addr); end
        // Grant held with zero debt must be ignored.
        rst = 1'b0; bus.aref_gnt = 1'b1;
        early = 0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i == 10) bus.aref_gnt = 1'b0;
            if (bus.aref_req !== 1'b0 || bus.aref_busy !== 1'b0) early++;
        end
        n_vec++; if (early != 0) begin n_err++; $display("FAIL early_req_or_busy got %0d cycles want 0", early); end
        @(negedge clk);
        n_vec++; if (bus.aref_req !== 1'b1) begin n_err++; $display("FAIL first_tick_req got %b want 1", bus.aref_req); end
        n_vec++; if (bus.aref_debt !== 3'd1) begin n_err++; $display("FAIL first_tick_debt got %0d want 1", bus.aref_debt); end
    endtask

    task automatic test_single();
        int bl, na, fa, la, np, no, df, dt;
        do_burst(bl, na, fa, la, np, no, df, dt);
        n_vec++; if (bl != 6) begin n_err++; $display("FAIL single_busy_len got %0d want 6", bl); end
        n_vec++; if (np != 1 || no != 0) begin n_err++; $display("FAIL single_pall_other got %0d/%0d want 1/0", np, no); end
        n_vec++; if (na != 1 || fa != 2) begin n_err++; $display("FAIL single_aref got n=%0d at %0d want n=1 at 2", na, fa); end
        n_vec++; if (df != 1 || dt != 1) begin n_err++; $display("FAIL single_done got fall=%0d total=%0d want 1/1", df, dt); end
        n_vec++; if (bus.aref_debt !== 3'd0 || bus.aref_req !== 1'b0) begin n_err++; $display("FAIL single_end got debt=%0d req=%b want 0/0", bus.aref_debt, bus.aref_req); end
    endtask

    task automatic test_postponed();
        int ok, bl, na, fa, la, np, no, df, dt;
        wait_debt(2, ok);
        n_vec++; if (ok != 1 || bus.aref_urgent !== 1'b0) begin n_err++; $display("FAIL debt2_urgent got ok=%0d urg=%b want 1/0", ok, bus.aref_urgent); end
        wait_debt(3, ok);
        n_vec++; if (ok != 1 || bus.aref_urgent !== 1'b1 || bus.aref_req !== 1'b1) begin n_err++; $display("FAIL debt3_urgent got ok=%0d urg=%b req=%b want 1/1/1", ok, bus.aref_urgent, bus.aref_req); end
        do_burst(bl, na, fa, la, np, no, df, dt);
        n_vec++; if (bl != 14) begin n_err++; $display("FAIL burst3_busy_len got %0d want 14", bl); end
        n_vec++; if (na != 3 || fa != 2 || la != 10) begin n_err++; $display("FAIL burst3_aref got n=%0d first=%0d last=%0d want 3/2/10", na, fa, la); end
        n_vec++; if (np != 1 || no != 0 || df != 1 || dt != 1) begin n_err++; $display("FAIL burst3_misc got pall=%0d other=%0d fall=%0d done=%0d want 1/0/1/1", np, no, df, dt); end
        n_vec++; if (bus.aref_debt !== 3'd0 || bus.aref_urgent !== 1'b0 || bus.aref_ovf !== 1'b0) begin n_err++; $display("FAIL burst3_end got debt=%0d urg=%b ovf=%b want 0/0/0", bus.aref_debt, bus.aref_urgent, bus.aref_ovf); end
    endtask

    task automatic test_overflow();
        int ok, bl, na, fa, la, np, no, df, dt;
        wait_debt(4, ok);
        n_vec++; if (ok != 1 || bus.aref_ovf !== 1'b0) begin n_err++; $display("FAIL debt4_no_ovf got ok=%0d ovf=%b want 1/0", ok, bus.aref_ovf); end
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.aref_ovf === 1'b1) begin ok = 1; break; end
        end
        n_vec++; if (ok != 1 || bus.aref_debt !== 3'd4) begin n_err++; $display("FAIL ovf_set got ok=%0d debt=%0d want 1/4", ok, bus.aref_debt); end
        do_burst(bl, na, fa, la, np, no, df, dt);
        n_vec++; if (bl != 18 || na != 4 || la != 14) begin n_err++; $display("FAIL burst4 got len=%0d n=%0d last=%0d want 18/4/14", bl, na, la); end
        n_vec++; if (bus.aref_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", bus.aref_ovf); end
    endtask

    task automatic test_coincident();
        logic [2:0] d0;
        int ok;
        d0 = bus.aref_debt;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.aref_debt !== d0) begin ok = 1; break; end
        end
        n_vec++; if (ok != 1 || bus.aref_debt !== 3'd2) begin n_err++; $display("FAIL coin_sync got ok=%0d debt=%0d want 1/2", ok, bus.aref_debt); end
        // Grant 17 edges after the tick puts the first AREF edge on the next tick.
        repeat (16) @(negedge clk);
        bus.aref_gnt = 1'b1;
        @(negedge clk);
        bus.aref_gnt = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.aref_cmd !== AREF || bus.aref_debt !== 3'd2) begin n_err++; $display("FAIL coin_pre got cmd=%b debt=%0d want 0001/2", bus.aref_cmd, bus.aref_debt); end
        @(negedge clk);
        n_vec++; if (bus.aref_debt !== 3'd2) begin n_err++; $display("FAIL coin_edge_debt got %0d want 2", bus.aref_debt); end
        repeat (7) @(negedge clk);
        n_vec++; if (bus.aref_busy !== 1'b0 || bus.aref_done !== 1'b1) begin n_err++; $display("FAIL coin_end got busy=%b done=%b want 0/1", bus.aref_busy, bus.aref_done); end
        n_vec++; if (bus.aref_req !== 1'b1 || bus.aref_debt !== 3'd1) begin n_err++; $display("FAIL coin_rereq got req=%b debt=%0d want 1/1", bus.aref_req, bus.aref_debt); end
    endtask

    task automatic test_init_drop();
        int bad, cnt;
        bus.aref_gnt = 1'b1;
        @(negedge clk);
        bus.aref_gnt = 1'b0;
        n_vec++; if (bus.aref_cmd !== PALL || bus.aref_busy !== 1'b1) begin n_err++; $display("FAIL drop_pall got cmd=%b busy=%b want 0010/1", bus.aref_cmd, bus.aref_busy); end
        @(negedge clk);
        bus.init_done = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.aref_busy !== 1'b0 || bus.aref_cmd !== NOP) begin n_err++; $display("FAIL drop_idle got busy=%b cmd=%b want 0/0111", bus.aref_busy, bus.aref_cmd); end
        n_vec++; if (bus.aref_debt !== 3'd0 || bus.aref_req !== 1'b0) begin n_err++; $display("FAIL drop_debt got debt=%0d req=%b want 0/0", bus.aref_debt, bus.aref_req); end
        n_vec++; if (bus.aref_ovf !== 1'b1) begin n_err++; $display("FAIL drop_ovf_kept got %b want 1", bus.aref_ovf); end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.aref_req !== 1'b0 || bus.aref_debt !== 3'd0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL held_no_req got %0d cycles want 0", bad); end
        bus.init_done = 1'b1;
        cnt = 0;
        while (bus.aref_req !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++; if (cnt != 20) begin n_err++; $display("FAIL restart_req_delay got %0d want 20", cnt); end
    endtask

    task automatic test_rst_mid();
        bus.aref_gnt = 1'b1;
        @(negedge clk);
        bus.aref_gnt = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.aref_busy !== 1'b1 || bus.aref_cmd !== NOP) begin n_err++; $display("FAIL rfc_wait got busy=%b cmd=%b want 1/0111", bus.aref_busy, bus.aref_cmd); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (bus.aref_busy !== 1'b0 || bus.aref_cmd !== NOP) begin n_err++; $display("FAIL async_rst got busy=%b cmd=%b want 0/0111", bus.aref_busy, bus.aref_cmd); end
        n_vec++; if (bus.aref_ovf !== 1'b0 || bus.aref_req !== 1'b0 || bus.aref_debt !== 3'd0) begin n_err++; $display("FAIL async_rst_state got ovf=%b req=%b debt=%0d want 0/0/0", bus.aref_ovf, bus.aref_req, bus.aref_debt); end
        repeat (3) @(negedge clk);
        n_vec++; if (bus.aref_busy !== 1'b0 || bus.aref_cmd !== NOP) begin n_err++; $display("FAIL rst_held got busy=%b cmd=%b want 0/0111", bus.aref_busy, bus.aref_cmd); end
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.init_done = 1'b1;
        bus.aref_gnt = 1'b0;
        test_reset();
        test_single();
        test_postponed();
        test_overflow();
        test_coincident();
        test_init_drop();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
